// File: rtl/kmkz_trap_ctrl_if.sv
// Execute-stage / fetch-redirect handshake between the Kamikaze-uRV pipeline and the trap controller.
interface kmkz_trap_ctrl_if;
  logic        x_valid_i;
  logic        x_stall_i;
  logic        x_kill_i;
  logic [31:0] x_pc_i;
  logic        x_exception_i;
  logic [3:0]  x_exception_cause_i;
  logic        x_is_mret_i;
  logic        d_is_csr_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] x_csr_write_value_i;
  logic [31:0] vector_base_i;
  logic        x_trap_kill_o;
  logic        f_redirect_o;
  logic [31:0] f_redirect_pc_o;
  logic        x_hold_o;

  modport slave (
    input  x_valid_i, x_stall_i, x_kill_i, x_pc_i, x_exception_i, x_exception_cause_i,
           x_is_mret_i, d_is_csr_i, d_csr_sel_i, x_csr_write_value_i, vector_base_i,
    output x_trap_kill_o, f_redirect_o, f_redirect_pc_o, x_hold_o
  );

  modport master (
    output x_valid_i, x_stall_i, x_kill_i, x_pc_i, x_exception_i, x_exception_cause_i,
           x_is_mret_i, d_is_csr_i, d_csr_sel_i, x_csr_write_value_i, vector_base_i,
    input  x_trap_kill_o, f_redirect_o, f_redirect_pc_o, x_hold_o
  );
endinterface

// File: rtl/kmkz_trap_ctrl.sv
// Trap/interrupt controller: machine CSRs, take decision at execute, fetch redirect and MRET sequencing.
// Optional macro KMKZ_IRQ_SYNC_EN adds 2-flop synchronizers on irq_i / timer_irq_i.
module kmkz_trap_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  kmkz_trap_ctrl_if.slave    xif,
  input  logic               timer_irq_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        csr_mstatus_o,
  output logic [31:0]        csr_mie_o,
  output logic [31:0]        csr_mip_o,
  output logic [31:0]        csr_mepc_o,
  output logic [31:0]        csr_mcause_o,
  output logic [31:0]        csr_irq_cause_o
);

  localparam logic [11:0] CSR_ID_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_ID_MIE       = 12'h304;
  localparam logic [11:0] CSR_ID_MEPC      = 12'h341;
  localparam logic [11:0] CSR_ID_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_ID_MIP       = 12'h344;
  localparam logic [11:0] CSR_ID_IRQ_CAUSE = 12'hFC0;

  typedef enum logic [1:0] {S_IDLE, S_REDIR, S_HOLD} state_e;
  typedef enum logic [1:0] {TK_NONE, TK_TRAP, TK_RET} take_e;

  logic [NUM_IRQ-1:0] irq_eff;
  logic               tmr_eff;

`ifdef KMKZ_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_s0_q, irq_s1_q;
  logic               tmr_s0_q, tmr_s1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_s0_q <= '0;
      irq_s1_q <= '0;
      tmr_s0_q <= 1'b0;
      tmr_s1_q <= 1'b0;
    end else begin
      irq_s0_q <= irq_i;
      irq_s1_q <= irq_s0_q;
      tmr_s0_q <= timer_irq_i;
      tmr_s1_q <= tmr_s0_q;
    end
  end

  assign irq_eff = irq_s1_q;
  assign tmr_eff = tmr_s1_q;
`else
  assign irq_eff = irq_i;
  assign tmr_eff = timer_irq_i;
`endif

  logic meip, mtip;
  logic [4:0] irq_idx;

  assign meip = |irq_eff;
  assign mtip = tmr_eff;

  // Scan downward so the lowest set line is the last one written.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_eff[i]) irq_idx = 5'(i);
    end
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] rpc_q, rpc_d;
  logic        fire, irq_pend;
  take_e       take;

  assign irq_pend = mie_q & ((meip & meie_q) | (mtip & mtie_q));
  assign fire     = xif.x_valid_i & ~xif.x_stall_i & ~xif.x_kill_i & (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    meie_d   = meie_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    rpc_d    = rpc_q;
    take     = TK_NONE;

    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (xif.x_exception_i) begin
            take     = TK_TRAP;
            mcause_d = {28'h0, xif.x_exception_cause_i};
          end else if (irq_pend) begin
            take     = TK_TRAP;
            mcause_d = (meip & meie_q) ? 32'h8000_000B : 32'h8000_0007;
          end else if (xif.x_is_mret_i) begin
            take = TK_RET;
          end else if (xif.d_is_csr_i) begin
            case (xif.d_csr_sel_i)
              CSR_ID_MSTATUS: begin
                mie_d  = xif.x_csr_write_value_i[3];
                mpie_d = xif.x_csr_write_value_i[7];
              end
              CSR_ID_MIE: begin
                mtie_d = xif.x_csr_write_value_i[7];
                meie_d = xif.x_csr_write_value_i[11];
              end
              CSR_ID_MEPC:   mepc_d   = {xif.x_csr_write_value_i[31:1], 1'b0};
              CSR_ID_MCAUSE: mcause_d = xif.x_csr_write_value_i;
              CSR_ID_MIP, CSR_ID_IRQ_CAUSE: ;
              default: ;
            endcase
          end
        end

        if (take == TK_TRAP) begin
          mepc_d  = xif.x_pc_i;
          mpie_d  = mie_q;
          mie_d   = 1'b0;
          rpc_d   = xif.vector_base_i;
          state_d = S_REDIR;
        end else if (take == TK_RET) begin
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          rpc_d   = mepc_q;
          state_d = S_REDIR;
        end
      end
      // The redirect pulse is fetch-side and never stretched by an execute stall.
      S_REDIR: begin
        cnt_d   = 4'(HOLD_CYCLES - 1);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else if (!xif.x_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      meie_q   <= meie_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      rpc_q    <= rpc_d;
    end
  end

  assign xif.x_trap_kill_o   = (take == TK_TRAP);
  assign xif.f_redirect_o    = (state_q == S_REDIR);
  assign xif.f_redirect_pc_o = rpc_q;
  assign xif.x_hold_o        = (state_q != S_IDLE);

  assign csr_mstatus_o   = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
  assign csr_mie_o       = {20'h0, meie_q, 3'b000, mtie_q, 7'h00};
  assign csr_mip_o       = {20'h0, meip, 3'b000, mtip, 7'h00};
  assign csr_mepc_o      = mepc_q;
  assign csr_mcause_o    = mcause_q;
  assign csr_irq_cause_o = {meip, 26'h0, irq_idx};

endmodule
